result_writeback: RTL and testbench



---
 rtl/result_writeback.sv | 195 +++++++++++++++++++
 tb/tb_result_writeback.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback.sv
// Result-stream writeback: tracks tile/in-tile beat position, buffers beats with their word address, drives the memory write port.
// Optional macro RESULT_WB_OVERFLOW_CHECK_EN enables the sticky overflow detector (otherwise overflow is tied low).
module result_writeback #(
    parameter int unsigned ARRAY_HEIGHT = 4,
    parameter int unsigned ARRAY_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned BUS_WIDTH    = 256,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [15:0]           m,
    input  logic [15:0]           p,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [BUS_WIDTH-1:0]  data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0]  mem_wdata,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned E    = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned CB_N = ARRAY_WIDTH / E;
    localparam int unsigned E_SH = $clog2(E);
    localparam int unsigned RW   = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int unsigned CBW  = (CB_N > 1) ? $clog2(CB_N) : 1;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [15:0]           m_q, p_q;
    logic [ADDR_WIDTH-1:0] stride, row_off, tile_base, row_base;
    logic [RW-1:0]         row_cnt;
    logic [CBW-1:0]        cb_cnt;
    logic [16:0]           col_pos, tr_pos;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;

    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [BUS_WIDTH-1:0]  data_mem [FIFO_DEPTH];

    logic                  r_last, cb_last, tc_last, tr_last, last_beat;
    logic                  pop, full, push, drain_done;
    logic [ADDR_WIDTH-1:0] beat_addr, row_base_nx, head_addr;
    logic [BUS_WIDTH-1:0]  head_data;
    logic [PW-1:0]         rd_nx;
    logic [CW-1:0]         count_nx;

    // Position decode and FIFO bookkeeping
    always_comb begin
        r_last      = (row_cnt == RW'(ARRAY_HEIGHT - 1));
        cb_last     = (cb_cnt == CBW'(CB_N - 1));
        tc_last     = ((col_pos + 17'(ARRAY_WIDTH)) == {1'b0, p_q});
        tr_last     = ((tr_pos + 17'(ARRAY_HEIGHT)) == {1'b0, m_q});
        last_beat   = r_last & cb_last & tc_last & tr_last;
        beat_addr   = tile_base + row_off + ADDR_WIDTH'(cb_cnt);
        // At the last row of a tile, row_off + stride equals H*stride
        row_base_nx = row_base + row_off + stride;
        pop         = mem_we & mem_ready;
        full        = (count == CW'(FIFO_DEPTH));
        push        = (state == RUN) & valid_i & (~full | pop);
        count_nx    = CW'(count + CW'(push) - CW'(pop));
        rd_nx       = PW'(rd_ptr + PW'(pop));
        drain_done  = (count == '0) | ((count == CW'(1)) & pop);
        // A beat written into the slot that becomes the head bypasses the array
        if (push && (wr_ptr == rd_nx)) begin
            head_addr = beat_addr;
            head_data = data_i;
        end else begin
            head_addr = addr_mem[rd_nx];
            head_data = data_mem[rd_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= beat_addr;
            data_mem[wr_ptr] <= data_i;
        end
    end

    // FSM, position counters, FIFO pointers and registered write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            m_q       <= '0;
            p_q       <= '0;
            stride    <= '0;
            row_off   <= '0;
            tile_base <= '0;
            row_base  <= '0;
            row_cnt   <= '0;
            cb_cnt    <= '0;
            col_pos   <= '0;
            tr_pos    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done   <= 1'b0;
            wr_ptr <= PW'(wr_ptr + PW'(push));
            rd_ptr <= rd_nx;
            count  <= count_nx;
            mem_we <= (count_nx != '0);
            if (count_nx != '0) begin
                mem_addr  <= head_addr;
                mem_wdata <= head_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        m_q       <= m;
                        p_q       <= p;
                        stride    <= ADDR_WIDTH'(p >> E_SH);
                        row_off   <= '0;
                        tile_base <= base_addr;
                        row_base  <= base_addr;
                        row_cnt   <= '0;
                        cb_cnt    <= '0;
                        col_pos   <= '0;
                        tr_pos    <= '0;
                    end
                end
                RUN: begin
                    // Positions advance on every valid beat, dropped or not
                    if (valid_i) begin
                        if (!r_last) begin
                            row_cnt <= RW'(row_cnt + 1'b1);
                            row_off <= row_off + stride;
                        end else begin
                            row_cnt <= '0;
                            row_off <= '0;
                            if (!cb_last) begin
                                cb_cnt <= CBW'(cb_cnt + 1'b1);
                            end else begin
                                cb_cnt <= '0;
                                if (!tc_last) begin
                                    col_pos   <= col_pos + 17'(ARRAY_WIDTH);
                                    tile_base <= tile_base + ADDR_WIDTH'(CB_N);
                                end else begin
                                    col_pos   <= '0;
                                    tr_pos    <= tr_pos + 17'(ARRAY_HEIGHT);
                                    row_base  <= row_base_nx;
                                    tile_base <= row_base_nx;
                                end
                            end
                        end
                        if (last_beat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RESULT_WB_OVERFLOW_CHECK_EN
    // Sticky: dropped full-FIFO beat, or any beat outside RUN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if ((state == IDLE) && start) begin
            overflow <= 1'b0;
        end else if (valid_i && ((state != RUN) || (full && !pop))) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_result_writeback.sv
// Directed self-checking bench for result_writeback (H=4, W=32, E=16, FIFO depth 8).
module tb_result_writeback;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [15:0]  m, p;
    logic [31:0]  base_addr;
    logic [255:0] data_i;
    logic         valid_i;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_we;
    logic         mem_ready;
    logic         busy, done, overflow;

    int errors = 0;
    int checks = 0;

    logic [31:0]  wa [0:255];
    logic [255:0] wd [0:255];
    int           n_wr   = 0;
    int           n_done = 0;

`ifdef RESULT_WB_OVERFLOW_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    result_writeback dut (
        .clk(clk), .reset_n(reset_n), .start(start), .m(m), .p(p),
        .base_addr(base_addr), .data_i(data_i), .valid_i(valid_i),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake and done-pulse log
    always @(posedge clk) begin
        if (mem_we && mem_ready && n_wr < 256) begin
            wa[n_wr] = mem_addr;
            wd[n_wr] = mem_wdata;
            n_wr++;
        end
        if (done) n_done++;
    end

    function automatic logic [255:0] mk(input int k);
        return {8{32'hC0DE0000 + 32'(k)}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] mm, input logic [15:0] pp, input logic [31:0] ba);
        m = mm; p = pp; base_addr = ba; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 256'(busy), 256'(1));
    endtask

    task automatic send(input int k);
        valid_i = 1'b1;
        data_i  = mk(k);
        tick();
        valid_i = 1'b0;
    endtask

    // Waits for busy to fall (bounded) and checks done pulses with it
    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_idle_timeout"}, 256'(busy), 256'(0));
        check({tag, "_done_with_busy_fall"}, 256'(done), 256'(1));
        tick();
        check({tag, "_done_one_cycle"}, 256'(done), 256'(0));
    endtask

    // Address of beat position pos in an m x p matrix (H=4, W=32, E=16)
    function automatic logic [31:0] exp_addr(input int pos, input int pp, input logic [31:0] ba);
        int r, cb, tc, tr, ntc;
        ntc = pp / 32;
        r   = pos % 4;
        cb  = (pos / 4) % 2;
        tc  = (pos / 8) % ntc;
        tr  = pos / (8 * ntc);
        return ba + 32'((tr * 4 + r) * (pp / 16) + tc * 2 + cb);
    endfunction

    initial begin
        int b0, nd0;
        logic [31:0] tab1 [8];
        logic [31:0] tab2 [16];
        tab1 = '{32'h100, 32'h102, 32'h104, 32'h106, 32'h101, 32'h103, 32'h105, 32'h107};
        tab2 = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

        reset_n = 1'b0; start = 1'b0; m = '0; p = '0; base_addr = '0;
        data_i = '0; valid_i = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("rst_mem_we", 256'(mem_we), 256'(0));
        check("rst_mem_addr", 256'(mem_addr), 256'(0));
        check("rst_mem_wdata", mem_wdata, 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_overflow", 256'(overflow), 256'(0));

        // Single tile, back-to-back beats
        b0 = n_wr; nd0 = n_done;
        do_start(16'd4, 16'd32, 32'h100);
        send(100);
        check("s1_first_we", 256'(mem_we), 256'(1));
        check("s1_first_addr", 256'(mem_addr), 256'(32'h100));
        check("s1_first_data", mem_wdata, mk(100));
        for (int k = 1; k < 8; k++) send(100 + k);
        wait_idle("s1");
        check("s1_nwrites", 256'(n_wr - b0), 256'(8));
        check("s1_ndone", 256'(n_done - nd0), 256'(1));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s1_addr%0d", i), 256'(wa[b0 + i]), 256'(tab1[i]));
            check($sformatf("s1_data%0d", i), wd[b0 + i], mk(100 + i));
        end

        // Multi-tile 8x64
        b0 = n_wr; nd0 = n_done;
        do_start(16'd8, 16'd64, 32'h0);
        for (int k = 0; k < 32; k++) send(200 + k);
        wait_idle("s2");
        check("s2_nwrites", 256'(n_wr - b0), 256'(32));
        check("s2_ndone", 256'(n_done - nd0), 256'(1));
        for (int i = 0; i < 16; i++)
            check($sformatf("s2_tab%0d", i), 256'(wa[b0 + i]), 256'(tab2[i]));
        check("s2_tile10_start", 256'(wa[b0 + 16]), 256'(16));
        for (int i = 16; i < 32; i++)
            check($sformatf("s2_addr%0d", i), 256'(wa[b0 + i]), 256'(exp_addr(i, 64, 32'h0)));
        check("s2_data31", wd[b0 + 31], mk(231));

        // Backpressure: 20 stalled cycles, 8 beats
        b0 = n_wr;
        mem_ready = 1'b0;
        do_start(16'd4, 16'd32, 32'h200);
        for (int k = 0; k < 8; k++) send(300 + k);
        for (int c = 0; c < 12; c++) begin
            check($sformatf("s3_stall_we%0d", c), 256'(mem_we), 256'(1));
            check($sformatf("s3_stall_addr%0d", c), 256'(mem_addr), 256'(32'h200));
            tick();
        end
        check("s3_stall_data", mem_wdata, mk(300));
        check("s3_no_writes_in_stall", 256'(n_wr - b0), 256'(0));
        mem_ready = 1'b1;
        wait_idle("s3");
        check("s3_nwrites", 256'(n_wr - b0), 256'(8));
        check("s3_overflow", 256'(overflow), 256'(0));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s3_addr%0d", i), 256'(wa[b0 + i]), 256'(exp_addr(i, 32, 32'h200)));
            check($sformatf("s3_data%0d", i), wd[b0 + i], mk(300 + i));
        end

        // Overflow: 9 beats into a full stalled FIFO (4x64, 16 beats)
        b0 = n_wr;
        mem_ready = 1'b0;
        do_start(16'd4, 16'd64, 32'h0);
        for (int k = 0; k < 8; k++) send(400 + k);
        check("s4_ovf_before_drop", 256'(overflow), 256'(0));
        send(408);
        check("s4_ovf_after_drop", 256'(overflow), 256'(OVF_EXP));
        for (int c = 0; c < 11; c++) tick();
        mem_ready = 1'b1;
        begin
            int n = 0;
            while (mem_we !== 1'b0 && n < 50) begin tick(); n++; end
        end
        check("s4_drained", 256'(n_wr - b0), 256'(8));
        for (int k = 9; k < 16; k++) send(400 + k);
        wait_idle("s4");
        check("s4_nwrites", 256'(n_wr - b0), 256'(15));
        check("s4_pos10_addr", 256'(wa[b0 + 8]), 256'(6));
        check("s4_pos10_data", wd[b0 + 8], mk(409));
        for (int i = 0; i < 8; i++)
            check($sformatf("s4_addr%0d", i), 256'(wa[b0 + i]), 256'(exp_addr(i, 64, 32'h0)));
        for (int i = 9; i < 16; i++)
            check($sformatf("s4_addr%0d", i), 256'(wa[b0 + i - 1]), 256'(exp_addr(i, 64, 32'h0)));
        check("s4_ovf_sticky", 256'(overflow), 256'(OVF_EXP));

        // Reset after 3 of 8 beats, then a clean rerun
        do_start(16'd4, 16'd32, 32'h300);
        check("s5_ovf_cleared_by_start", 256'(overflow), 256'(0));
        for (int k = 0; k < 3; k++) send(500 + k);
        reset_n = 1'b0;
        #1;
        check("s5_rst_we", 256'(mem_we), 256'(0));
        check("s5_rst_addr", 256'(mem_addr), 256'(0));
        check("s5_rst_wdata", mem_wdata, 256'(0));
        check("s5_rst_busy", 256'(busy), 256'(0));
        check("s5_rst_done", 256'(done), 256'(0));
        check("s5_rst_overflow", 256'(overflow), 256'(0));
        tick();
        reset_n = 1'b1;
        tick();
        b0 = n_wr;
        do_start(16'd4, 16'd32, 32'h300);
        for (int k = 0; k < 8; k++) send(600 + k);
        wait_idle("s5");
        check("s5_nwrites", 256'(n_wr - b0), 256'(8));
        for (int i = 0; i < 8; i++)
            check($sformatf("s5_addr%0d", i), 256'(wa[b0 + i]), 256'(exp_addr(i, 32, 32'h300)));
        check("s5_data0", wd[b0], mk(600));

        // Beat while idle is ignored
        b0 = n_wr;
        send(700);
        tick();
        check("s6_idle_no_we", 256'(mem_we), 256'(0));
        check("s6_idle_no_write", 256'(n_wr - b0), 256'(0));
        check("s6_idle_overflow", 256'(overflow), 256'(OVF_EXP));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
